// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the execute-stage ALU
package alu_pkg;

  // Operation codes produced by the ALU control decoder
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_LUI     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0110;
  localparam logic [3:0] ALU_INVALID = 4'b1001;

  // Sequencer states: IDLE accepts work, SHIFT walks the SLL one bit per cycle
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - single-cycle ALU ops and opcode legality; overflow output under ALU_OVERFLOW_EN
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            alu_operation,
  input  logic                  shamt_sel,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  logic [DATA_WIDTH-1:0] sum;

  assign sum = a_in + b_in;

  // Decode the opcode; SLL passes b through so a zero-count shift finishes in one cycle
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_operation)
      ALU_AND: result = a_in & b_in;
      ALU_OR:  result = a_in | b_in;
      ALU_NOR: result = ~(a_in | b_in);
      ALU_ADD: result = sum;
      ALU_LUI: result = {b_in[15:0], 16'h0000};
      ALU_SLL: result = b_in;
      default: illegal = 1'b1;
    endcase
    // The shamt-select bit must agree with the opcode in both directions
    if (shamt_sel != (alu_operation == ALU_SLL)) illegal = 1'b1;
    if (illegal) result = '0;
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operands share a sign that the sum does not
  assign overflow = !illegal && (alu_operation == ALU_ADD) &&
                    (a_in[DATA_WIDTH-1] == b_in[DATA_WIDTH-1]) &&
                    (sum[DATA_WIDTH-1] != a_in[DATA_WIDTH-1]);
`endif

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with iterative SLL and start/busy/done handshake; optional overflow via ALU_OVERFLOW_EN
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             alu_operation,
  input  logic                   shamt_sel,
  input  logic [DATA_WIDTH-1:0]  a_in,
  input  logic [DATA_WIDTH-1:0]  b_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   done,
  output logic                   busy,
  output logic                   illegal
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                   overflow
`endif
);

  alu_state_t             state;
  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0]  core_result;
  logic                   core_illegal;
  logic                   shift_start;
`ifdef ALU_OVERFLOW_EN
  logic                   core_overflow;
`endif

  alu_comb_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .alu_operation(alu_operation),
    .shamt_sel    (shamt_sel),
    .a_in         (a_in),
    .b_in         (b_in),
    .result       (core_result),
    .illegal      (core_illegal)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow     (core_overflow)
`endif
  );

  assign acc_next = acc << 1;

  // Only a well-formed SLL with a nonzero count needs the multi-cycle path
  assign shift_start = (alu_operation == ALU_SLL) && shamt_sel && (shamt != '0);

  // Sequencer: single-cycle ops complete from IDLE, SLL iterates in SHIFT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
`ifdef ALU_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          if (shift_start) begin
            acc   <= b_in;
            cnt   <= shamt;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            result   <= core_result;
            zero     <= (core_result == '0);
            illegal  <= core_illegal;
            done     <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            overflow <= core_overflow;
`endif
          end
        end
      end else begin
        acc <= acc_next;
        cnt <= cnt - 1'b1;
        if (cnt == SHAMT_WIDTH'(1)) begin
          result   <= acc_next;
          zero     <= (acc_next == '0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
`ifdef ALU_OVERFLOW_EN
          overflow <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - randomized self-checking bench for alu_seq_exec against a behavioural model
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_operation = 4'd0;
  logic        shamt_sel = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] result;
  logic        zero;
  logic        done;
  logic        busy;
  logic        illegal;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_exec #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .alu_operation(alu_operation),
    .shamt_sel    (shamt_sel),
    .a_in         (a_in),
    .b_in         (b_in),
    .shamt        (shamt),
    .result       (result),
    .zero         (zero),
    .done         (done),
    .busy         (busy),
    .illegal      (illegal)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow     (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: result, illegal flag, signed overflow and cycles to done
  function automatic void ref_op(input logic [3:0] op, input logic sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r,
                                 output logic ill, output logic ovf, output int lat);
    longint s;
    r = 32'd0; ill = 1'b0; ovf = 1'b0; lat = 1;
    if (sel != (op == 4'd6)) ill = 1'b1;
    else begin
      case (op)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = ~(a | b);
        4'd3: begin
          r = a + b;
          s = longint'($signed(a)) + longint'($signed(b));
          ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'd5: r = {b[15:0], 16'h0000};
        4'd6: begin
          r = b << sh;
          lat = int'(sh) + 1;
        end
        default: ill = 1'b1;
      endcase
    end
  endfunction

  // Issue one start, scramble inputs while waiting, optionally poke start mid-shift
  task automatic run_op(input string tag, input logic [3:0] op, input logic sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic        ei;
    logic        eo;
    int          elat;
    int          lat;
    int          nbusy;
    ref_op(op, sel, a, b, sh, er, ei, eo, elat);
    alu_operation = op; shamt_sel = sel; a_in = a; b_in = b; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; shamt = 5'($urandom);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 64) begin
      if (busy) nbusy++;
      start = (poke && busy) ? 1'b1 : 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    check_eq({tag, " latency"}, lat, elat);
    check_eq({tag, " busy cycles"}, nbusy, elat - 1);
    check_eq({tag, " result"}, result, er);
    check_eq({tag, " zero"}, zero, (er == 32'd0));
    check_eq({tag, " illegal"}, illegal, ei);
    check_eq({tag, " busy at done"}, busy, 1'b0);
`ifdef ALU_OVERFLOW_EN
    check_eq({tag, " overflow"}, overflow, eo);
`endif
    tick();
    check_eq({tag, " done one cycle"}, done, 1'b0);
    check_eq({tag, " illegal cleared"}, illegal, 1'b0);
    check_eq({tag, " result held"}, result, er);
  endtask

  initial begin
    logic [3:0] legal_ops [6];
    logic [3:0] op;
    logic       sel;
    int         ndone;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};

    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("reset result", result, 32'd0);
    check_eq("reset zero", zero, 1'b1);
    check_eq("reset done", done, 1'b0);
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset illegal", illegal, 1'b0);

    run_op("add_ovf", 4'd3, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    run_op("sll4", 4'd6, 1'b1, 32'h1234_5678, 32'h0000_0003, 5'd4, 1'b1);
    run_op("sll0", 4'd6, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    run_op("sll31", 4'd6, 1'b1, 32'h0, 32'h0000_0003, 5'd31, 1'b1);
    run_op("invalid", 4'b1001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op("sel_mismatch", 4'd3, 1'b1, 32'h5, 32'h6, 5'd3, 1'b0);
    run_op("sll_nosel", 4'd6, 1'b0, 32'h5, 32'h6, 5'd3, 1'b0);

    // Back-to-back single-cycle ops
    alu_operation = 4'd5; shamt_sel = 1'b0; a_in = 32'hAAAA_AAAA; b_in = 32'h0000_1234; start = 1'b1;
    tick();
    check_eq("b2b lui done", done, 1'b1);
    check_eq("b2b lui result", result, 32'h1234_0000);
    alu_operation = 4'd2; a_in = 32'd0; b_in = 32'd0;
    tick();
    check_eq("b2b nor done", done, 1'b1);
    check_eq("b2b nor result", result, 32'hFFFF_FFFF);
    alu_operation = 4'd0; a_in = 32'hF0F0_F0F0; b_in = 32'h0F0F_0F0F;
    tick();
    start = 1'b0;
    check_eq("b2b and done", done, 1'b1);
    check_eq("b2b and result", result, 32'd0);
    check_eq("b2b and zero", zero, 1'b1);
    tick();
    check_eq("b2b done drop", done, 1'b0);

    // Reset during the third busy cycle of a 20-bit shift
    run_op("pre_reset", 4'd1, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 5'd0, 1'b0);
    alu_operation = 4'd6; shamt_sel = 1'b1; b_in = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("pre-abort busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort result", result, 32'd0);
    check_eq("abort zero", zero, 1'b1);
    check_eq("abort busy", busy, 1'b0);
    check_eq("abort done", done, 1'b0);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("abort no done", ndone, 0);
    check_eq("abort result held", result, 32'd0);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 5)];
      else op = 4'($urandom_range(0, 15));
      sel = (op == 4'd6);
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      run_op("random", op, sel,
             ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit operation code and the shamt-select bit from the decoder, plus two operands and a shift amount.
- Logic ops, ADD and LUI complete in one cycle. SLL is computed iteratively, one bit per cycle, so the block carries a start/busy/done handshake toward the datapath sequencer.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be 32 for LUI semantics.
- SHAMT_WIDTH, 5, shift-amount width; equals log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- alu_operation  input  4  operation code from ALU control.
- shamt_sel  input  1  1 = shift op; takes shift count from shamt.
- a_in  input  DATA_WIDTH  operand A (rs).
- b_in  input  DATA_WIDTH  operand B (rt or extended immediate).
- shamt  input  SHAMT_WIDTH  shift amount.
- result  output  DATA_WIDTH  registered result; held until the next accepted start.
- zero  output  1  registered, result==0.
- done  output  1  one-cycle pulse; result valid.
- busy  output  1  high while shifting; start is ignored.
- illegal  output  1  pulses with done for unsupported codes.

Behaviour:
- Reset asserts asynchronously, any state:
  - state=IDLE; result=0; zero=1; done=0; busy=0; illegal=0; counter=0.
  - A shift in flight is aborted and no done is produced.
- Operation codes:
  - 0000 AND: a&b.
  - 0001 OR: a|b.
  - 0010 NOR: ~(a|b).
  - 0011 ADD: a+b mod 2^32; carry-out dropped.
  - 0101 LUI: {b[15:0],16'h0000}.
  - 0110 SLL: b<<shamt.
  - Any other code (incl. 1001): result=0, illegal=1.
- FSM state IDLE (busy=0):
  - Non-shift start at edge N: result/zero/illegal updated at edge N+1; done=1 during cycle N+1; FSM stays IDLE.
  - Back-to-back starts are accepted every cycle, 1-cycle latency.
- SLL start in IDLE:
  - shamt=0: behaves as a 1-cycle op; result=b.
  - shamt=k>0: acc<=b, cnt<=k, go to SHIFT.
- FSM state SHIFT (busy=1):
  - Each cycle: acc<=acc<<1, cnt<=cnt-1.
  - When cnt==1: result<=acc<<1, zero updated, done pulse, return to IDLE.
  - Total latency k+1 cycles from the start edge; done in cycle N+1+k; busy high cycles N+1..N+k.
- start while busy=1: ignored, no queueing; inputs are not re-sampled.
- Operands are captured at start. Input changes during SHIFT do not affect the result.
- shamt_sel and alu_operation must agree: 0110 implies shamt_sel=1.
  - Mismatch (either direction) is treated as illegal: result=0, 1-cycle done.
- done and illegal are never high outside the completion cycle.
- result and zero hold their value between completions.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit).
  - overflow is registered with result and set for ADD when a[31]==b[31] and sum[31]!=a[31].
  - overflow is cleared by any other completion and reset to 0.
  - result is still written (no trap).
- Undefined: no port, no logic; ADD wraps silently.

Decomposition:
- Package alu_pkg:
  - opcode localparams ALU_AND, ALU_OR, ALU_NOR, ALU_ADD, ALU_LUI, ALU_SLL, ALU_INVALID (4'b1001).
  - FSM state encoding ST_IDLE, ST_SHIFT.
- Sub-module alu_comb_core: purely combinational single-cycle ops (AND/OR/NOR/ADD/LUI, illegal decode, optional overflow).
- Top level owns the FSM, shift accumulator, counter and output registers.

Test Plan:
- Reset released, no start: result=0, zero=1, done=0, busy=0.
- ADD, a=32'h7FFF_FFFF, b=1, start one cycle: next cycle done=1, result=32'h8000_0000, zero=0.
  - With ALU_OVERFLOW_EN: overflow=1.
- SLL, b=32'h0000_0003, shamt=4: busy high 4 cycles; done in cycle 5 after start; result=32'h0000_0030.
  - A start asserted mid-shift produces no extra done.
- SLL with shamt=0, b=32'hDEAD_BEEF: done after 1 cycle, result=32'hDEAD_BEEF, busy never high.
- Back-to-back starts:
  - LUI b=32'h0000_1234 → result=32'h1234_0000.
  - Then NOR a=0,b=0 → result=32'hFFFF_FFFF.
  - Then AND a=32'hF0F0_F0F0,b=32'h0F0F_0F0F → result=0, zero=1.
  - done high 3 consecutive cycles.
- Code 4'b1001 → done=1, illegal=1, result=0.
- SLL shamt=20 with reset asserted in cycle 3 of the shift: outputs return to reset values immediately; no done.
